// File: rtl/mac_seq.sv
// mac_seq: sequencer that streams len operand pairs from a dual operand
// memory into an external multiply-accumulate unit, drains its pipeline,
// loads the MAC output register and captures the finished dot product.
module mac_seq #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 5,
    parameter int RES_W  = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] a_out_mac,
    output logic [DATA_W-1:0] b_out_mac,
    output logic              acc_clr,
    output logic              ld_mac,
    input  logic [RES_W-1:0]  mac_out_in,
    output logic [RES_W-1:0]  result,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_LOAD,
        S_CAPT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_drain;
    logic              r_rdValid;
    logic [DATA_W-1:0] r_aOp;
    logic [DATA_W-1:0] r_bOp;
    logic [RES_W-1:0]  r_result;
    logic              w_accept;
    logic              w_lastRead;

    // A zero-length request never leaves IDLE, so it is filtered here.
    assign w_accept   = start && (len != '0);
    assign w_lastRead = (r_addr == (r_len - ADDR_ONE));

    assign rd_addr   = r_addr;
    assign a_out_mac = r_aOp;
    assign b_out_mac = r_bOp;
    assign result    = r_result;

    // State register; reset drops straight back to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic: read len pairs, drain two cycles, then load, capture, done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_READ;
            S_READ:  if (w_lastRead) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_LOAD;
            S_LOAD:  w_next = S_CAPT;
            S_CAPT:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; the accumulator clear fires on the first read cycle only.
    always_comb begin
        busy    = (r_state != S_IDLE);
        rd_en   = (r_state == S_READ);
        acc_clr = (r_state == S_READ) && (r_addr == '0);
        ld_mac  = (r_state == S_LOAD);
        done    = (r_state == S_DONE);
    end

    // Length latch, read address counter and the 1-bit drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len   <= '0;
            r_addr  <= '0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_len <= len;
                    r_addr  <= '0;
                    r_drain <= 1'b0;
                end
                S_READ:  r_addr <= w_lastRead ? '0 : (r_addr + ADDR_ONE);
                S_DRAIN: r_drain <= ~r_drain;
                default: begin
                    r_addr  <= '0;
                    r_drain <= 1'b0;
                end
            endcase
        end
    end

    // Operand pipeline: the MAC adds every cycle, so operands are zero unless
    // fresh memory data is arriving this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdValid <= 1'b0;
            r_aOp     <= '0;
            r_bOp     <= '0;
        end else begin
            r_rdValid <= (r_state == S_READ);
            r_aOp     <= r_rdValid ? a_rdata : '0;
            r_bOp     <= r_rdValid ? b_rdata : '0;
        end
    end

    // Result capture straight from the MAC output register, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_result <= '0;
        else if (r_state == S_CAPT)  r_result <= mac_out_in;
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: bench for mac_seq with an operand memory model, a behavioural
// MAC, and a cycle-timeline reference derived from the sequencing rules.
module tb_mac_seq;

    localparam int DATA_W = 13;
    localparam int ADDR_W = 5;
    localparam int RES_W  = 25;
    localparam int MAXC   = 40;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic [DATA_W-1:0] a_out_mac;
    logic [DATA_W-1:0] b_out_mac;
    logic              acc_clr;
    logic              ld_mac;
    logic [RES_W-1:0]  mac_out_in;
    logic [RES_W-1:0]  result;
    logic              done;

    logic [DATA_W-1:0] memA [0:31];
    logic [DATA_W-1:0] memB [0:31];
    logic [RES_W-1:0]  macAcc;
    logic [RES_W-1:0]  macOut;
    logic [RES_W-1:0]  aExt;
    logic [RES_W-1:0]  bExt;

    int nChecks;
    int nFails;

    logic [4:0]        obsCtl    [0:MAXC-1];
    logic [ADDR_W-1:0] obsAddr   [0:MAXC-1];
    logic [DATA_W-1:0] obsA      [0:MAXC-1];
    logic [DATA_W-1:0] obsB      [0:MAXC-1];
    logic [RES_W-1:0]  obsResult [0:MAXC-1];
    int                doneCount;
    int                doneCycle;
    logic [RES_W-1:0]  resAtDone;
    logic [RES_W-1:0]  modelResult;

    mac_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .a_out_mac  (a_out_mac),
        .b_out_mac  (b_out_mac),
        .acc_clr    (acc_clr),
        .ld_mac     (ld_mac),
        .mac_out_in (mac_out_in),
        .result     (result),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous operand memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= memA[rd_addr];
            b_rdata <= memB[rd_addr];
        end
    end

    assign aExt = {{(RES_W-DATA_W){1'b0}}, a_out_mac};
    assign bExt = {{(RES_W-DATA_W){1'b0}}, b_out_mac};

    // Behavioural MAC: accumulate every cycle, clear on pulse, load output on strobe.
    always @(posedge clk) begin
        if (acc_clr) macAcc <= '0;
        else         macAcc <= macAcc + aExt * bExt;
        if (ld_mac)  macOut <= macAcc;
    end
    assign mac_out_in = macOut;

    // Dot product of the first n pairs, reduced to the result width.
    function automatic logic [RES_W-1:0] expectedDot(input int n);
        longint s;
        longint pa;
        s = 0;
        for (int k = 0; k < n; k++) begin
            pa = longint'(memA[k]);
            s  = s + pa * longint'(memB[k]);
        end
        return s[RES_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request starting in the current (IDLE) cycle and records
    // the outputs of cycles 0..n+6; optionally pulses start again at glitchAt.
    task automatic applyStimulus(input int n, input int glitchAt, input logic [ADDR_W-1:0] glitchLen);
        logic [ADDR_W-1:0] nv;
        nv        = ADDR_W'(n);
        doneCount = 0;
        doneCycle = -1;
        resAtDone = '0;
        start     = 1'b1;
        len       = nv;
        for (int c = 0; c <= n + 6; c++) begin
            if (c > 0) begin
                tick();
                start = (c == glitchAt);
                if (c == glitchAt) len = glitchLen;
            end
            obsCtl[c]    = {busy, rd_en, acc_clr, ld_mac, done};
            obsAddr[c]   = rd_addr;
            obsA[c]      = a_out_mac;
            obsB[c]      = b_out_mac;
            obsResult[c] = result;
            if (done) begin
                doneCount++;
                doneCycle = c;
                resAtDone = result;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        nChecks++;
        if ({busy, rd_en, acc_clr, ld_mac, done} !== 5'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ctl: got %b required 00000", {busy, rd_en, acc_clr, ld_mac, done});
        end
        nChecks++;
        if ({rd_addr, a_out_mac, b_out_mac, result} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_data: addr=%0d a=%0d b=%0d result=%0d required all 0",
                     rd_addr, a_out_mac, b_out_mac, result);
        end
    endtask

    task automatic test_len1();
        logic [7:0] ldSeen;
        memA[0] = 13'd3;
        memB[0] = 13'd4;
        applyStimulus(1, -1, '0);
        nChecks++;
        if (doneCount !== 1 || doneCycle !== 6) begin
            nFails++;
            $display("[TB] FAIL len1_done: count=%0d cycle=%0d required count=1 cycle=6", doneCount, doneCycle);
        end
        nChecks++;
        if (resAtDone !== 25'd12) begin
            nFails++;
            $display("[TB] FAIL len1_result: got %0d required 12", resAtDone);
        end
        for (int c = 0; c < 8; c++) ldSeen[c] = obsCtl[c][1];
        nChecks++;
        if (ldSeen !== 8'b0001_0000) begin
            nFails++;
            $display("[TB] FAIL len1_ld_mac: cycles %b required 00010000", ldSeen);
        end
        modelResult = 25'd12;
    endtask

    task automatic test_len3();
        for (int k = 0; k < 3; k++) begin
            memA[k] = DATA_W'(2 * k + 1);
            memB[k] = DATA_W'(2 * k + 2);
        end
        applyStimulus(3, -1, '0);
        nChecks++;
        if (doneCycle !== 8 || resAtDone !== 25'd44) begin
            nFails++;
            $display("[TB] FAIL len3_result: cycle=%0d result=%0d required cycle=8 result=44", doneCycle, resAtDone);
        end
        nChecks++;
        if (obsA[2] !== '0 || obsA[7] !== '0) begin
            nFails++;
            $display("[TB] FAIL len3_zero_ops: a[2]=%0d a[7]=%0d required 0 and 0", obsA[2], obsA[7]);
        end
        nChecks++;
        if ({obsA[3], obsA[4], obsA[5]} !== {13'd1, 13'd3, 13'd5} ||
            {obsB[3], obsB[4], obsB[5]} !== {13'd2, 13'd4, 13'd6}) begin
            nFails++;
            $display("[TB] FAIL len3_pairs: a=%0d,%0d,%0d b=%0d,%0d,%0d required a=1,3,5 b=2,4,6",
                     obsA[3], obsA[4], obsA[5], obsB[3], obsB[4], obsB[5]);
        end
        modelResult = 25'd44;
    endtask

    task automatic test_len0();
        int bad;
        bad   = 0;
        start = 1'b1;
        len   = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({busy, rd_en, done, acc_clr, ld_mac} !== 5'b0) bad++;
        end
        start = 1'b0;
        nChecks++;
        if (bad !== 0) begin
            nFails++;
            $display("[TB] FAIL len0_idle: %0d cycles had outputs active, required 0", bad);
        end
        nChecks++;
        if (result !== modelResult) begin
            nFails++;
            $display("[TB] FAIL len0_result: got %0d required %0d", result, modelResult);
        end
    endtask

    task automatic test_start_ignored();
        for (int k = 0; k < 3; k++) begin
            memA[k] = DATA_W'(2 * k + 1);
            memB[k] = DATA_W'(2 * k + 2);
        end
        applyStimulus(3, 2, 5'd7);
        nChecks++;
        if (doneCount !== 1 || doneCycle !== 8) begin
            nFails++;
            $display("[TB] FAIL ignore_start_done: count=%0d cycle=%0d required count=1 cycle=8", doneCount, doneCycle);
        end
        nChecks++;
        if (resAtDone !== 25'd44) begin
            nFails++;
            $display("[TB] FAIL ignore_start_result: got %0d required 44", resAtDone);
        end
        modelResult = 25'd44;
    endtask

    task automatic test_reset_mid_run();
        int sawDone;
        int sawBusy;
        for (int k = 0; k < 3; k++) begin
            memA[k] = DATA_W'(2 * k + 1);
            memB[k] = DATA_W'(2 * k + 2);
        end
        start = 1'b1;
        len   = 5'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        nChecks++;
        if ({busy, rd_en, acc_clr, ld_mac, done} !== 5'b0 ||
            {rd_addr, a_out_mac, b_out_mac, result} !== '0) begin
            nFails++;
            $display("[TB] FAIL async_reset: ctl=%b addr=%0d a=%0d b=%0d result=%0d required all 0",
                     {busy, rd_en, acc_clr, ld_mac, done}, rd_addr, a_out_mac, b_out_mac, result);
        end
        sawDone = 0;
        sawBusy = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) sawDone++;
            if (busy) sawBusy++;
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) sawDone++;
            if (busy) sawBusy++;
        end
        nChecks++;
        if (sawDone !== 0 || sawBusy !== 0) begin
            nFails++;
            $display("[TB] FAIL reset_abandon: done=%0d busy=%0d cycles required 0 and 0", sawDone, sawBusy);
        end
        memA[0] = 13'd2;
        memB[0] = 13'd5;
        applyStimulus(1, -1, '0);
        nChecks++;
        if (resAtDone !== 25'd10 || doneCycle !== 6 || obsCtl[1][2] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL post_reset_run: result=%0d cycle=%0d acc_clr@1=%b required 10, 6, 1",
                     resAtDone, doneCycle, obsCtl[1][2]);
        end
        modelResult = 25'd10;
    endtask

    task automatic test_back_to_back();
        int clr1;
        int clr2;
        logic [RES_W-1:0] r1;
        logic [RES_W-1:0] r2;
        int d2;
        memA[0] = 13'd1; memB[0] = 13'd1;
        memA[1] = 13'd2; memB[1] = 13'd2;
        applyStimulus(2, -1, '0);
        r1   = resAtDone;
        clr1 = 0;
        for (int c = 0; c <= 8; c++) clr1 += int'(obsCtl[c][2]);
        memA[0] = 13'd3; memB[0] = 13'd3;
        memA[1] = 13'd1; memB[1] = 13'd1;
        applyStimulus(2, -1, '0);
        r2   = resAtDone;
        d2   = doneCycle;
        clr2 = 0;
        for (int c = 0; c <= 8; c++) clr2 += int'(obsCtl[c][2]);
        nChecks++;
        if (r1 !== 25'd5 || r2 !== 25'd10) begin
            nFails++;
            $display("[TB] FAIL b2b_results: got %0d then %0d required 5 then 10", r1, r2);
        end
        nChecks++;
        if (clr1 !== 1 || clr2 !== 1 || d2 !== 7) begin
            nFails++;
            $display("[TB] FAIL b2b_timing: acc_clr %0d/%0d second done cycle %0d required 1/1 and 7",
                     clr1, clr2, d2);
        end
        modelResult = 25'd10;
    endtask

    task automatic test_random();
        int lens [0:4];
        int n;
        logic [4:0]        expCtl;
        logic [DATA_W-1:0] expA;
        logic [DATA_W-1:0] expB;
        logic [RES_W-1:0]  expRes;
        logic [RES_W-1:0]  expHeld;
        lens[0] = 31;
        for (int i = 1; i < 5; i++) lens[i] = int'($urandom_range(2, 30));
        for (int r = 0; r < 5; r++) begin
            n = lens[r];
            for (int k = 0; k < 32; k++) begin
                memA[k] = DATA_W'($urandom_range(0, 8191));
                memB[k] = DATA_W'($urandom_range(0, 8191));
            end
            expRes = expectedDot(n);
            applyStimulus(n, -1, '0);
            for (int c = 0; c <= n + 6; c++) begin
                expCtl = {(c >= 1 && c <= n + 5), (c >= 1 && c <= n), (c == 1), (c == n + 3), (c == n + 5)};
                expA   = (c >= 3 && c <= n + 2) ? memA[c - 3] : '0;
                expB   = (c >= 3 && c <= n + 2) ? memB[c - 3] : '0;
                expHeld = (c >= n + 5) ? expRes : modelResult;
                nChecks++;
                if (obsCtl[c] !== expCtl) begin
                    nFails++;
                    $display("[TB] FAIL rand_ctl len=%0d cycle=%0d: busy/rd/clr/ld/done=%b required %b",
                             n, c, obsCtl[c], expCtl);
                end
                nChecks++;
                if (obsA[c] !== expA || obsB[c] !== expB || obsResult[c] !== expHeld ||
                    (expCtl[3] && obsAddr[c] !== ADDR_W'(c - 1))) begin
                    nFails++;
                    $display("[TB] FAIL rand_data len=%0d cycle=%0d: a=%0d b=%0d res=%0d addr=%0d required a=%0d b=%0d res=%0d addr=%0d",
                             n, c, obsA[c], obsB[c], obsResult[c], obsAddr[c], expA, expB, expHeld, c - 1);
                end
            end
            modelResult = expRes;
        end
    endtask

    // Scenario sequence: reset, directed cases, reset abort, back-to-back, random runs.
    initial begin
        nChecks     = 0;
        nFails      = 0;
        modelResult = '0;
        rst         = 1'b0;
        start       = 1'b0;
        len         = '0;
        #2;
        test_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_len1();
        test_len3();
        test_len0();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
